// File: rtl/line_miss_handler_p.sv
// Miss-service initiator for one cache way: victim writeback, line fill, install.
// Optional MISS_STATS_EN adds saturating miss/writeback counters (stat_miss_o, stat_wb_o).
module line_miss_handler_p #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5,
  parameter int S_TAG    = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_req_i,
  input  logic [31:0]                miss_addr_i,
  output logic                       miss_done_o,
  output logic [S_INDEX-1:0]         way_index_o,
  output logic [S_TAG-1:0]           way_tag_o,
  output logic [(8<<S_OFFSET)-1:0]   way_data_o,
  output logic [(1<<S_OFFSET)-1:0]   way_byte_enable_o,
  output logic                       way_load_o,
  output logic                       way_load_dirty_o,
  output logic                       way_mem_write_o,
  input  logic [S_TAG-1:0]           way_tag_i,
  input  logic                       way_valid_i,
  input  logic                       way_dirty_i,
  input  logic [(8<<S_OFFSET)-1:0]   way_data_i,
  output logic                       pmem_read_o,
  output logic                       pmem_write_o,
  output logic [31:0]                pmem_addr_o,
  output logic [(8<<S_OFFSET)-1:0]   pmem_wdata_o,
  input  logic [(8<<S_OFFSET)-1:0]   pmem_rdata_i,
`ifdef MISS_STATS_EN
  output logic [15:0]                stat_miss_o,
  output logic [15:0]                stat_wb_o,
`endif
  input  logic                       pmem_resp_i
);

  localparam int LINE_W = 8 << S_OFFSET;
  localparam int BE_W   = 1 << S_OFFSET;

  typedef enum logic [2:0] {IDLE, CHECK, WB, FILL, INSTALL} state_t;

  state_t              state, state_next;
  logic [S_TAG-1:0]    miss_tag;
  logic [S_INDEX-1:0]  miss_index;
  logic [S_TAG-1:0]    victim_tag;
  logic [LINE_W-1:0]   victim_line;
  logic [LINE_W-1:0]   fill_line;

  // Byte offset bits never matter: the whole line moves.
  logic unused_offset;
  assign unused_offset = ^miss_addr_i[S_OFFSET-1:0];

  assign way_index_o = miss_index;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      miss_tag    <= '0;
      miss_index  <= '0;
      victim_tag  <= '0;
      victim_line <= '0;
      fill_line   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (miss_req_i) begin
          miss_tag   <= miss_addr_i[31 -: S_TAG];
          miss_index <= miss_addr_i[S_OFFSET +: S_INDEX];
        end
        CHECK: if (way_valid_i && way_dirty_i) begin
          victim_tag  <= way_tag_i;
          victim_line <= way_data_i;
        end
        FILL: if (pmem_resp_i) fill_line <= pmem_rdata_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next        = state;
    miss_done_o       = 1'b0;
    way_tag_o         = '0;
    way_data_o        = '0;
    way_byte_enable_o = '0;
    way_load_o        = 1'b0;
    way_load_dirty_o  = 1'b0;
    way_mem_write_o   = 1'b0;
    pmem_read_o       = 1'b0;
    pmem_write_o      = 1'b0;
    pmem_addr_o       = '0;
    pmem_wdata_o      = '0;
    case (state)
      IDLE:  if (miss_req_i) state_next = CHECK;
      CHECK: state_next = (way_valid_i && way_dirty_i) ? WB : FILL;
      WB: begin
        pmem_write_o = 1'b1;
        pmem_addr_o  = {victim_tag, miss_index, {S_OFFSET{1'b0}}};
        pmem_wdata_o = victim_line;
        if (pmem_resp_i) state_next = FILL;
      end
      FILL: begin
        pmem_read_o = 1'b1;
        pmem_addr_o = {miss_tag, miss_index, {S_OFFSET{1'b0}}};
        if (pmem_resp_i) state_next = INSTALL;
      end
      INSTALL: begin
        // Freshly filled line is installed valid and clean.
        way_load_o        = 1'b1;
        way_load_dirty_o  = 1'b1;
        way_mem_write_o   = 1'b0;
        way_byte_enable_o = {BE_W{1'b1}};
        way_tag_o         = miss_tag;
        way_data_o        = fill_line;
        miss_done_o       = 1'b1;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef MISS_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_miss_o <= '0;
      stat_wb_o   <= '0;
    end else begin
      if (state == IDLE && miss_req_i) stat_miss_o <= sat_inc(stat_miss_o);
      if (state == WB && pmem_resp_i)  stat_wb_o   <= sat_inc(stat_wb_o);
    end
  end
`endif

endmodule

// File: tb/tb_line_miss_handler_p.sv
// Bench for line_miss_handler_p: way/memory models, transaction monitor, reference predictor.
module tb_line_miss_handler_p;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req_i;
  logic [31:0]  miss_addr_i;
  logic         miss_done_o;
  logic [2:0]   way_index_o;
  logic [23:0]  way_tag_o;
  logic [255:0] way_data_o;
  logic [31:0]  way_byte_enable_o;
  logic         way_load_o, way_load_dirty_o, way_mem_write_o;
  logic [23:0]  way_tag_i;
  logic         way_valid_i, way_dirty_i;
  logic [255:0] way_data_i;
  logic         pmem_read_o, pmem_write_o;
  logic [31:0]  pmem_addr_o;
  logic [255:0] pmem_wdata_o;
  logic [255:0] pmem_rdata_i;
  logic         pmem_resp_i;
`ifdef MISS_STATS_EN
  logic [15:0]  stat_miss_o, stat_wb_o;
`endif

  always #5 clk = ~clk;

  line_miss_handler_p dut (
    .clk(clk), .rst(rst), .miss_req_i(miss_req_i), .miss_addr_i(miss_addr_i),
    .miss_done_o(miss_done_o), .way_index_o(way_index_o), .way_tag_o(way_tag_o),
    .way_data_o(way_data_o), .way_byte_enable_o(way_byte_enable_o),
    .way_load_o(way_load_o), .way_load_dirty_o(way_load_dirty_o),
    .way_mem_write_o(way_mem_write_o), .way_tag_i(way_tag_i), .way_valid_i(way_valid_i),
    .way_dirty_i(way_dirty_i), .way_data_i(way_data_i), .pmem_read_o(pmem_read_o),
    .pmem_write_o(pmem_write_o), .pmem_addr_o(pmem_addr_o), .pmem_wdata_o(pmem_wdata_o),
    .pmem_rdata_i(pmem_rdata_i),
`ifdef MISS_STATS_EN
    .stat_miss_o(stat_miss_o), .stat_wb_o(stat_wb_o),
`endif
    .pmem_resp_i(pmem_resp_i)
  );

  // Way contents as the bench believes them to be; the DUT reads the victim from here.
  logic [23:0]  m_tag   [8];
  logic         m_valid [8];
  logic         m_dirty [8];
  logic [255:0] m_data  [8];
  assign way_tag_i   = m_tag[way_index_o];
  assign way_valid_i = m_valid[way_index_o];
  assign way_dirty_i = m_dirty[way_index_o];
  assign way_data_i  = m_data[way_index_o];

  logic [255:0] mem [logic [31:0]];
  int n_cmp = 0, n_err = 0;
  int fixed_delay = -1;
  int stab_err = 0, both_err = 0, illegal_err = 0;
  int exp_miss = 0, exp_wb = 0;

  typedef struct packed {
    logic [2:0] idx; logic [23:0] tag; logic [255:0] data; logic [31:0] be;
    logic ld; logic ldd; logic mw;
  } inst_t;
  logic [31:0]  wr_addr_q[$];
  logic [255:0] wr_data_q[$];
  logic [31:0]  rd_addr_q[$];
  inst_t        inst_q[$];

  wire [608:0] outs = {miss_done_o, way_index_o, way_tag_o, way_data_o, way_byte_enable_o,
                       way_load_o, way_load_dirty_o, way_mem_write_o, pmem_read_o,
                       pmem_write_o, pmem_addr_o, pmem_wdata_o};

  function automatic logic [255:0] mem_peek(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {4{a, ~a}};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Memory responder: completes each request after a fixed or random number of cycles.
  initial begin : responder
    int cnt;
    bit waiting;
    cnt = 0; waiting = 0;
    pmem_resp_i = 1'b0; pmem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (pmem_resp_i) begin
        pmem_resp_i = 1'b0; waiting = 0;
      end else if (rst && (pmem_read_o || pmem_write_o)) begin
        if (!waiting) begin
          waiting = 1;
          cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
        end
        if (cnt == 0) begin
          pmem_resp_i = 1'b1;
          if (pmem_write_o) mem[pmem_addr_o] = pmem_wdata_o;
          else pmem_rdata_i = mem_peek(pmem_addr_o);
        end else cnt--;
      end else waiting = 0;
    end
  end

  // Monitor: collects completed transactions and protocol violations.
  initial begin : monitor
    logic p_wr, p_rd;
    logic [31:0] p_addr;
    logic [255:0] p_wdata;
    p_wr = 0; p_rd = 0; p_addr = '0; p_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        if (pmem_resp_i) begin
          if (p_wr) begin wr_addr_q.push_back(p_addr); wr_data_q.push_back(p_wdata); end
          if (p_rd) rd_addr_q.push_back(p_addr);
        end else if (p_wr || p_rd) begin
          if (pmem_write_o !== p_wr || pmem_read_o !== p_rd || pmem_addr_o !== p_addr ||
              (p_wr && pmem_wdata_o !== p_wdata)) stab_err++;
        end
      end
      if (pmem_read_o && pmem_write_o) both_err++;
      if (pmem_addr_o[4:0] !== 5'd0) illegal_err++;
      if (miss_done_o === 1'b1)
        inst_q.push_back('{way_index_o, way_tag_o, way_data_o, way_byte_enable_o,
                           way_load_o, way_load_dirty_o, way_mem_write_o});
      else if (way_byte_enable_o !== '0 || way_load_o !== 1'b0 || way_load_dirty_o !== 1'b0)
        illegal_err++;
      p_wr = pmem_write_o; p_rd = pmem_read_o; p_addr = pmem_addr_o; p_wdata = pmem_wdata_o;
    end
  end

  // Reference: what one miss must do, derived from the victim state and memory contents.
  logic         e_wr;
  logic [2:0]   e_idx;
  logic [23:0]  e_tag;
  logic [31:0]  e_wr_addr, e_rd_addr;
  logic [255:0] e_wr_data, e_fill;

  task automatic predict(input logic [31:0] a);
    e_idx     = a[7:5];
    e_tag     = a[31:8];
    e_wr      = m_valid[e_idx] && m_dirty[e_idx];
    e_wr_addr = {m_tag[e_idx], e_idx, 5'b0};
    e_wr_data = m_data[e_idx];
    e_rd_addr = {e_tag, e_idx, 5'b0};
    e_fill    = (e_wr && e_wr_addr == e_rd_addr) ? e_wr_data : mem_peek(e_rd_addr);
    exp_miss++;
    if (e_wr) exp_wb++;
  endtask

  task automatic commit();
    m_tag[e_idx] = e_tag; m_data[e_idx] = e_fill; m_valid[e_idx] = 1; m_dirty[e_idx] = 0;
  endtask

  task automatic run_miss(input logic [31:0] a, input bit keep, output bit to);
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); inst_q.delete();
    miss_addr_i = a; miss_req_i = 1'b1;
    to = 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (inst_q.size() > 0) begin to = 0; break; end
    end
    if (!keep || to) begin
      miss_req_i = 1'b0;
      repeat (3) @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; miss_req_i = 1'b0; miss_addr_i = '0;
    for (int i = 0; i < 8; i++) begin
      m_tag[i] = '0; m_valid[i] = 0; m_dirty[i] = 0; m_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (outs !== '0) begin n_err++; $display("FAIL reset_outs: got %h want 0", outs); end
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (outs !== '0) begin n_err++; $display("FAIL idle_outs: got %h want 0", outs); end
    exp_miss = 0; exp_wb = 0;
  endtask

  task automatic test_invalid_victim();
    bit to;
    m_valid[2] = 0; m_dirty[2] = 1; m_tag[2] = 24'h777777;
    predict(32'h0000_1240);
    run_miss(32'h0000_1240, 0, to);
    n_cmp++;
    if (to || wr_addr_q.size() != 0 || rd_addr_q.size() != 1 || inst_q.size() != 1) begin
      n_err++;
      $display("FAIL inv_counts: got to=%0d wr=%0d rd=%0d done=%0d want 0 0 1 1",
               to, wr_addr_q.size(), rd_addr_q.size(), inst_q.size());
    end else begin
      n_cmp++;
      if (rd_addr_q[0] !== 32'h0000_1240) begin
        n_err++; $display("FAIL inv_rd_addr: got %h want 00001240", rd_addr_q[0]);
      end
      n_cmp++;
      if (inst_q[0].idx !== 3'd2 || inst_q[0].tag !== 24'h000012 ||
          inst_q[0].be !== 32'hFFFF_FFFF) begin
        n_err++;
        $display("FAIL inv_install: got idx=%0d tag=%h be=%h want 2 000012 ffffffff",
                 inst_q[0].idx, inst_q[0].tag, inst_q[0].be);
      end
      n_cmp++;
      if (inst_q[0].data !== mem_peek(32'h0000_1240)) begin
        n_err++; $display("FAIL inv_data: got %h want %h", inst_q[0].data, mem_peek(32'h0000_1240));
      end
    end
    commit();
  endtask

  task automatic test_dirty_victim();
    bit to;
    logic [255:0] vdata;
    vdata = rand256();
    m_valid[5] = 1; m_dirty[5] = 1; m_tag[5] = 24'hABCDEF; m_data[5] = vdata;
    predict(32'h1234_56A0);
    run_miss(32'h1234_56A0, 0, to);
    n_cmp++;
    if (to || wr_addr_q.size() != 1 || rd_addr_q.size() != 1 || inst_q.size() != 1) begin
      n_err++;
      $display("FAIL dirty_counts: got to=%0d wr=%0d rd=%0d done=%0d want 0 1 1 1",
               to, wr_addr_q.size(), rd_addr_q.size(), inst_q.size());
    end else begin
      n_cmp++;
      if (wr_addr_q[0] !== 32'hABCD_EFA0 || wr_data_q[0] !== vdata) begin
        n_err++; $display("FAIL dirty_wb: got addr=%h want abcdefa0 (data match=%0d)",
                          wr_addr_q[0], wr_data_q[0] === vdata);
      end
      n_cmp++;
      if (rd_addr_q[0] !== 32'h1234_56A0) begin
        n_err++; $display("FAIL dirty_rd_addr: got %h want 123456a0", rd_addr_q[0]);
      end
      n_cmp++;
      if (inst_q[0].idx !== 3'd5 || inst_q[0].tag !== 24'h123456 || inst_q[0].ld !== 1'b1 ||
          inst_q[0].ldd !== 1'b1 || inst_q[0].mw !== 1'b0 ||
          inst_q[0].data !== mem_peek(32'h1234_56A0)) begin
        n_err++;
        $display("FAIL dirty_install: got idx=%0d tag=%h ld=%b ldd=%b mw=%b want 5 123456 1 1 0",
                 inst_q[0].idx, inst_q[0].tag, inst_q[0].ld, inst_q[0].ldd, inst_q[0].mw);
      end
    end
    commit();
  endtask

  task automatic test_clean_victim();
    bit to;
    // Set 5 now holds tag 123456, valid and clean.
    predict(32'h0BAD_F0A0);
    run_miss(32'h0BAD_F0A0, 0, to);
    n_cmp++;
    if (to || wr_addr_q.size() != 0 || rd_addr_q.size() != 1 || inst_q.size() != 1) begin
      n_err++;
      $display("FAIL clean_counts: got to=%0d wr=%0d rd=%0d done=%0d want 0 0 1 1",
               to, wr_addr_q.size(), rd_addr_q.size(), inst_q.size());
    end else begin
      n_cmp++;
      if (rd_addr_q[0] !== 32'h0BAD_F0A0 || inst_q[0].tag !== 24'h0BADF0 ||
          inst_q[0].ldd !== 1'b1 || inst_q[0].mw !== 1'b0) begin
        n_err++;
        $display("FAIL clean_install: got rd=%h tag=%h ldd=%b mw=%b want 0badf0a0 0badf0 1 0",
                 rd_addr_q[0], inst_q[0].tag, inst_q[0].ldd, inst_q[0].mw);
      end
    end
    commit();
  endtask

  task automatic test_slow_memory();
    bit to;
    int s0;
    s0 = stab_err;
    fixed_delay = 10;
    m_valid[3] = 1; m_dirty[3] = 1; m_tag[3] = 24'h00C0DE; m_data[3] = rand256();
    predict(32'h5555_5560);
    run_miss(32'h5555_5560, 0, to);
    fixed_delay = -1;
    n_cmp++;
    if (to || wr_addr_q.size() != 1 || rd_addr_q.size() != 1 || inst_q.size() != 1 ||
        wr_addr_q[0] !== e_wr_addr || rd_addr_q[0] !== e_rd_addr) begin
      n_err++;
      $display("FAIL slow_txn: got to=%0d wr=%0d rd=%0d done=%0d want 0 1 1 1 at %h/%h",
               to, wr_addr_q.size(), rd_addr_q.size(), inst_q.size(), e_wr_addr, e_rd_addr);
    end
    n_cmp++;
    if (stab_err != s0) begin
      n_err++; $display("FAIL slow_stable: got %0d unstable cycles want 0", stab_err - s0);
    end
    commit();
  endtask

  task automatic test_reset_in_wb();
    bit to, seen;
    m_valid[6] = 1; m_dirty[6] = 1; m_tag[6] = 24'hFEED00; m_data[6] = rand256();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); inst_q.delete();
    fixed_delay = 20;
    miss_addr_i = 32'h0000_00C0; miss_req_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #2;
      seen = pmem_write_o;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL rstwb_enter: got no write strobe want write"); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    miss_req_i = 1'b0;
    n_cmp++;
    if (outs !== '0) begin n_err++; $display("FAIL rstwb_outs: got %h want 0", outs); end
    @(negedge clk) rst = 1'b1;
    exp_miss = 0; exp_wb = 0;
    fixed_delay = -1;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (inst_q.size() != 0 || wr_addr_q.size() != 0) begin
      n_err++; $display("FAIL rstwb_partial: got done=%0d wr=%0d want 0 0",
                        inst_q.size(), wr_addr_q.size());
    end
    predict(32'h0000_00C0);
    run_miss(32'h0000_00C0, 0, to);
    n_cmp++;
    if (to || wr_addr_q.size() != 1 || inst_q.size() != 1 || wr_addr_q[0] !== 32'hFEED_00C0 ||
        rd_addr_q[0] !== 32'h0000_00C0 || inst_q[0].tag !== 24'h000000 ||
        inst_q[0].data !== e_fill) begin
      n_err++;
      $display("FAIL rstwb_retry: got to=%0d wr=%0d done=%0d want 0 1 1", to,
               wr_addr_q.size(), inst_q.size());
    end
    commit();
  endtask

  task automatic test_back_to_back();
    bit to;
    predict(32'hCAFE_0100);
    run_miss(32'hCAFE_0100, 1, to);
    n_cmp++;
    if (to || inst_q.size() != 1 || inst_q[0].tag !== 24'hCAFE01) begin
      n_err++; $display("FAIL b2b_first: got to=%0d done=%0d want 0 1", to, inst_q.size());
    end
    commit();
    // Request left high: the same address is serviced again, now against a clean victim.
    predict(32'hCAFE_0100);
    run_miss(32'hCAFE_0100, 0, to);
    n_cmp++;
    if (to || wr_addr_q.size() != 0 || rd_addr_q.size() != 1 || inst_q.size() != 1 ||
        rd_addr_q[0] !== 32'hCAFE_0100) begin
      n_err++;
      $display("FAIL b2b_second: got to=%0d wr=%0d rd=%0d done=%0d want 0 0 1 1",
               to, wr_addr_q.size(), rd_addr_q.size(), inst_q.size());
    end
    commit();
  endtask

  task automatic test_random();
    bit to, ok;
    logic [31:0] a;
    int bad;
    bad = 0;
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      m_valid[a[7:5]] = $urandom_range(0, 3) != 0;
      m_dirty[a[7:5]] = $urandom_range(0, 1);
      if ($urandom_range(0, 1)) m_tag[a[7:5]] = $urandom;
      m_data[a[7:5]] = rand256();
      predict(a);
      run_miss(a, 0, to);
      ok = !to && wr_addr_q.size() == (e_wr ? 1 : 0) && rd_addr_q.size() == 1 &&
           inst_q.size() == 1;
      if (ok) ok = (!e_wr || (wr_addr_q[0] === e_wr_addr && wr_data_q[0] === e_wr_data)) &&
                   rd_addr_q[0] === e_rd_addr && inst_q[0].idx === e_idx &&
                   inst_q[0].tag === e_tag && inst_q[0].data === e_fill &&
                   inst_q[0].be === 32'hFFFF_FFFF && inst_q[0].ld === 1'b1 &&
                   inst_q[0].ldd === 1'b1 && inst_q[0].mw === 1'b0;
      n_cmp++;
      if (!ok) begin
        n_err++; bad++;
        if (bad < 5)
          $display("FAIL rand_miss %0d: addr=%h got wr=%0d rd=%0d done=%0d want wr=%0d rd=%h",
                   n, a, wr_addr_q.size(), rd_addr_q.size(), inst_q.size(), e_wr, e_rd_addr);
      end
      commit();
    end
  endtask

`ifdef MISS_STATS_EN
  task automatic test_stats();
    bit to;
    n_cmp++;
    if (stat_miss_o !== exp_miss[15:0] || stat_wb_o !== exp_wb[15:0]) begin
      n_err++; $display("FAIL stats_run: got %0d/%0d want %0d/%0d",
                        stat_miss_o, stat_wb_o, exp_miss, exp_wb);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    exp_miss = 0; exp_wb = 0;
    for (int i = 0; i < 8; i++) m_dirty[i] = 0;
    m_valid[1] = 1; m_dirty[1] = 1; m_tag[1] = 24'h111111;
    predict(32'h0000_0020); run_miss(32'h0000_0020, 0, to); commit();
    predict(32'h0000_0040); run_miss(32'h0000_0040, 0, to); commit();
    predict(32'h0000_0060); run_miss(32'h0000_0060, 0, to); commit();
    n_cmp++;
    if (stat_miss_o !== 16'd3 || stat_wb_o !== 16'd1) begin
      n_err++; $display("FAIL stats_three: got %0d/%0d want 3/1", stat_miss_o, stat_wb_o);
    end
  endtask
`endif

  task automatic test_protocol();
    n_cmp++;
    if (stab_err != 0) begin n_err++; $display("FAIL stable: got %0d want 0", stab_err); end
    n_cmp++;
    if (both_err != 0) begin n_err++; $display("FAIL rd_wr_same_cycle: got %0d want 0", both_err); end
    n_cmp++;
    if (illegal_err != 0) begin
      n_err++; $display("FAIL idle_enables: got %0d want 0", illegal_err);
    end
  endtask

  initial begin
    test_reset();
    test_invalid_victim();
    test_dirty_victim();
    test_clean_victim();
    test_slow_memory();
    test_reset_in_wb();
    test_back_to_back();
    test_random();
`ifdef MISS_STATS_EN
    test_stats();
`endif
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
